// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, optional
// write-to-read bypass, optional hardwired zero register and a busy scoreboard.
module regfile_sb #(
    parameter int XLEN     = 64,
    parameter int AW       = 5,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [AW-1:0]   Ra,
    input  logic [AW-1:0]   Rb,
    output logic [XLEN-1:0] Da,
    output logic [XLEN-1:0] Db,
    input  logic            WE,
    input  logic [AW-1:0]   Rw,
    input  logic [XLEN-1:0] Din,
    input  logic            ISSUE,
    input  logic [AW-1:0]   Rd,
    input  logic            FLUSH,
    output logic            BUSY_A,
    output logic            BUSY_B,
    output logic [AW:0]     NBUSY
);

    localparam int NREGS = 1 << AW;

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    logic wr_ok;
    logic issue_ok;
    logic zero_a;
    logic zero_b;
    logic fwd_a;
    logic fwd_b;

    // A write to r0 is discarded entirely when r0 is hardwired.
    assign wr_ok    = WE    && !(ZERO_REG && (Rw == '0));
    assign issue_ok = ISSUE && !(ZERO_REG && (Rd == '0));

    assign zero_a = ZERO_REG && (Ra == '0);
    assign zero_b = ZERO_REG && (Rb == '0);
    assign fwd_a  = BYPASS && wr_ok && (Rw == Ra);
    assign fwd_b  = BYPASS && wr_ok && (Rw == Rb);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[Rw] <= Din;
        end
    end

    // Flush beats everything; a same-cycle issue beats the writeback clear
    // because the newly issued producer supersedes the completing one.
    always_comb begin
        busy_nxt = busy;
        if (FLUSH) begin
            busy_nxt = '0;
        end else begin
            if (WE) begin
                busy_nxt[Rw] = 1'b0;
            end
            if (issue_ok) begin
                busy_nxt[Rd] = 1'b1;
            end
        end
        if (ZERO_REG) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_comb begin
        Da     = regs[Ra];
        BUSY_A = busy[Ra];
        if (zero_a) begin
            Da     = '0;
            BUSY_A = 1'b0;
        end else if (fwd_a) begin
            Da     = Din;
            BUSY_A = 1'b0;
        end
    end

    always_comb begin
        Db     = regs[Rb];
        BUSY_B = busy[Rb];
        if (zero_b) begin
            Db     = '0;
            BUSY_B = 1'b0;
        end else if (fwd_b) begin
            Db     = Din;
            BUSY_B = 1'b0;
        end
    end

    always_comb begin
        NBUSY = '0;
        for (int i = 0; i < NREGS; i++) begin
            NBUSY = NBUSY + (AW+1)'(busy[i]);
        end
    end

endmodule
